// File: rtl/mem_resp_stage_pkg.sv
// Shared MEM-stage definitions: load-op encodings, pass-through field layout,
// exception codes and the latched EXE->MEM bundle.
package mem_resp_stage_pkg;

    localparam int PASS_W_DEF = 45;
    localparam int CNT_W_DEF  = 2;

    localparam logic [2:0] LD_OP_NONE = 3'd0;
    localparam logic [2:0] LD_OP_LW   = 3'd1;
    localparam logic [2:0] LD_OP_LH   = 3'd2;
    localparam logic [2:0] LD_OP_LHU  = 3'd3;
    localparam logic [2:0] LD_OP_LB   = 3'd4;
    localparam logic [2:0] LD_OP_LBU  = 3'd5;
    localparam logic [2:0] LD_OP_LWL  = 3'd6;
    localparam logic [2:0] LD_OP_LWR  = 3'd7;

    // Pass-through field layout; bits above the CP0 address are opaque.
    localparam int PASS_ERET    = 0;
    localparam int PASS_BD      = 1;
    localparam int PASS_MTC0_WE = 2;
    localparam int PASS_CP0_LSB = 3;
    localparam int PASS_CP0_W   = 8;

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0a;
    localparam logic [4:0] EXC_OV   = 5'h0c;

    typedef struct packed {
        logic [2:0]  ld_op;
        logic        need_resp;
        logic [1:0]  addr_lo;
        logic [31:0] rt_value;
        logic [31:0] alu_result;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] pc;
        logic        ex;
        logic [4:0]  excode;
    } ms_fields_t;

endpackage

// File: rtl/mem_resp_stage_load_align.sv
// Little-endian load-data alignment and LWL/LWR merge; purely combinational.
// No latency, no flow control: result follows inputs.
module mem_resp_stage_load_align
    import mem_resp_stage_pkg::*;
(
    input  logic [2:0]  ld_op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    input  logic [31:0] rt_value,
    input  logic [31:0] alu_result,
    output logic [31:0] result
);

    logic [15:0] half;
    logic [7:0]  byte_sel;

    assign half     = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    assign byte_sel = rdata[{addr_lo, 3'b000} +: 8];

    always_comb begin
        result = alu_result;
        case (ld_op)
            LD_OP_LW:  result = rdata;
            LD_OP_LH:  result = {{16{half[15]}}, half};
            LD_OP_LHU: result = {16'h0000, half};
            LD_OP_LB:  result = {{24{byte_sel[7]}}, byte_sel};
            LD_OP_LBU: result = {24'h000000, byte_sel};
            LD_OP_LWL: begin
                case (addr_lo)
                    2'd0:    result = {rdata[7:0],  rt_value[23:0]};
                    2'd1:    result = {rdata[15:0], rt_value[15:0]};
                    2'd2:    result = {rdata[23:0], rt_value[7:0]};
                    default: result = rdata;
                endcase
            end
            LD_OP_LWR: begin
                case (addr_lo)
                    2'd0:    result = rdata;
                    2'd1:    result = {rt_value[31:24], rdata[31:8]};
                    2'd2:    result = {rt_value[31:16], rdata[31:16]};
                    default: result = {rt_value[31:8],  rdata[31:24]};
                endcase
            end
            default:   result = alu_result;
        endcase
    end

endmodule

// File: rtl/mem_resp_stage.sv
// MEM stage waiting on split-transaction SRAM responses, dropping those of flushed loads.
// Zero added latency when data_ok meets a waiting load; read data is buffered while WB stalls.
module mem_resp_stage
    import mem_resp_stage_pkg::*;
#(
    parameter int PASS_W = PASS_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              es_to_ms_valid,
    output logic              ms_allowin,
    input  logic [2:0]        es_ld_op,
    input  logic              es_need_resp,
    input  logic [1:0]        es_addr_lo,
    input  logic [31:0]       es_rt_value,
    input  logic [31:0]       es_alu_result,
    input  logic              es_gr_we,
    input  logic [4:0]        es_dest,
    input  logic [31:0]       es_pc,
    input  logic              es_ex,
    input  logic [4:0]        es_excode,
    input  logic [PASS_W-1:0] es_pass,
    input  logic              es_cancel_req,
    input  logic              data_sram_data_ok,
    input  logic [31:0]       data_sram_rdata,
    input  logic              ws_allowin,
    output logic              ms_to_ws_valid,
    output logic              ms_ws_gr_we,
    output logic [4:0]        ms_ws_dest,
    output logic [31:0]       ms_ws_result,
    output logic [31:0]       ms_ws_pc,
    output logic [31:0]       ms_ws_alu_result,
    output logic              ms_ws_ex,
    output logic [4:0]        ms_ws_excode,
    output logic [PASS_W-1:0] ms_ws_pass,
    input  logic              ex_from_ws,
    output logic              ms_ex_to_es,
    output logic              fwd_valid,
    output logic [4:0]        fwd_dest,
    output logic [31:0]       fwd_data,
    output logic              fwd_block
);

    logic              ms_valid_q, ms_valid_d;
    logic              buf_valid_q, buf_valid_d;
    logic [31:0]       buf_q, buf_d;
    logic [CNT_W-1:0]  cancel_cnt_q, cancel_cnt_d;
    ms_fields_t        fields_q, fields_in;
    logic [PASS_W-1:0] pass_q;

    logic              cnt_zero, cnt_full, resp_hit, resp_drop, in_wait, ms_ready_go;
    logic [CNT_W-1:0]  cnt_inc, cnt_dec;
    logic [31:0]       load_data, result;

    assign cnt_zero    = (cancel_cnt_q == '0);
    assign cnt_full    = &cancel_cnt_q;
    assign resp_hit    = data_sram_data_ok && cnt_zero;
    assign resp_drop   = data_sram_data_ok && !cnt_zero;
    assign in_wait     = ms_valid_q && fields_q.need_resp && !buf_valid_q;
    assign ms_ready_go = !fields_q.need_resp || buf_valid_q || resp_hit;

    assign ms_allowin     = (!ms_valid_q || (ms_ready_go && ws_allowin)) && !cnt_full;
    assign ms_to_ws_valid = ms_valid_q && ms_ready_go;

    always_comb begin
        fields_in            = '0;
        fields_in.ld_op      = es_ld_op;
        fields_in.need_resp  = es_need_resp && !es_ex;
        fields_in.addr_lo    = es_addr_lo;
        fields_in.rt_value   = es_rt_value;
        fields_in.alu_result = es_alu_result;
        fields_in.gr_we      = es_gr_we;
        fields_in.dest       = es_dest;
        fields_in.pc         = es_pc;
        fields_in.ex         = es_ex;
        fields_in.excode     = es_excode;
    end

    // A waiting load that is flushed without its data leaves one orphan response behind.
    always_comb begin
        cnt_inc = '0;
        if (ex_from_ws) begin
            cnt_inc = CNT_W'(in_wait && !resp_hit) + CNT_W'(es_cancel_req);
        end
        cnt_dec = CNT_W'(resp_drop);
    end

    always_comb begin
        ms_valid_d   = ms_valid_q;
        buf_valid_d  = buf_valid_q;
        buf_d        = buf_q;
        cancel_cnt_d = cancel_cnt_q + cnt_inc - cnt_dec;
        if (ms_allowin) begin
            ms_valid_d = es_to_ms_valid;
        end
        if (resp_hit && in_wait) begin
            buf_valid_d = 1'b1;
            buf_d       = data_sram_rdata;
        end
        if (ms_to_ws_valid && ws_allowin) begin
            buf_valid_d = 1'b0;
        end
        if (ex_from_ws) begin
            ms_valid_d  = 1'b0;
            buf_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_valid_q   <= 1'b0;
            buf_valid_q  <= 1'b0;
            buf_q        <= '0;
            cancel_cnt_q <= '0;
            fields_q     <= '0;
            pass_q       <= '0;
        end else begin
            ms_valid_q   <= ms_valid_d;
            buf_valid_q  <= buf_valid_d;
            buf_q        <= buf_d;
            cancel_cnt_q <= cancel_cnt_d;
            if (es_to_ms_valid && ms_allowin) begin
                fields_q <= fields_in;
                pass_q   <= es_pass;
            end
        end
    end

    assign load_data = buf_valid_q ? buf_q : data_sram_rdata;

    mem_resp_stage_load_align u_align (
        .ld_op      (fields_q.ld_op),
        .addr_lo    (fields_q.addr_lo),
        .rdata      (load_data),
        .rt_value   (fields_q.rt_value),
        .alu_result (fields_q.alu_result),
        .result     (result)
    );

    assign ms_ws_gr_we      = fields_q.gr_we;
    assign ms_ws_dest       = fields_q.dest;
    assign ms_ws_result     = result;
    assign ms_ws_pc         = fields_q.pc;
    assign ms_ws_alu_result = fields_q.alu_result;
    assign ms_ws_ex         = fields_q.ex;
    assign ms_ws_excode     = fields_q.excode;
    assign ms_ws_pass       = pass_q;

    assign ms_ex_to_es = ms_valid_q && (fields_q.ex || pass_q[PASS_ERET]);
    assign fwd_valid   = ms_valid_q && fields_q.gr_we;
    assign fwd_dest    = fields_q.dest;
    assign fwd_data    = result;
    assign fwd_block   = ms_valid_q && (fields_q.ld_op != LD_OP_NONE) && !ms_ready_go;

endmodule

// File: tb/tb_mem_resp_stage.sv
// Directed bench for mem_resp_stage: alignment, buffering, cancel counter and async reset.
module tb_mem_resp_stage;

    localparam int PASS_W = 45;
    localparam int CNT_W  = 2;

    localparam logic [2:0] OP_NONE = 3'd0;
    localparam logic [2:0] OP_LW   = 3'd1;
    localparam logic [2:0] OP_LH   = 3'd2;
    localparam logic [2:0] OP_LBU  = 3'd5;
    localparam logic [2:0] OP_LWL  = 3'd6;
    localparam logic [2:0] OP_LWR  = 3'd7;

    logic              clk;
    logic              resetn;
    logic              es_to_ms_valid;
    logic              ms_allowin;
    logic [2:0]        es_ld_op;
    logic              es_need_resp;
    logic [1:0]        es_addr_lo;
    logic [31:0]       es_rt_value;
    logic [31:0]       es_alu_result;
    logic              es_gr_we;
    logic [4:0]        es_dest;
    logic [31:0]       es_pc;
    logic              es_ex;
    logic [4:0]        es_excode;
    logic [PASS_W-1:0] es_pass;
    logic              es_cancel_req;
    logic              data_sram_data_ok;
    logic [31:0]       data_sram_rdata;
    logic              ws_allowin;
    logic              ms_to_ws_valid;
    logic              ms_ws_gr_we;
    logic [4:0]        ms_ws_dest;
    logic [31:0]       ms_ws_result;
    logic [31:0]       ms_ws_pc;
    logic [31:0]       ms_ws_alu_result;
    logic              ms_ws_ex;
    logic [4:0]        ms_ws_excode;
    logic [PASS_W-1:0] ms_ws_pass;
    logic              ex_from_ws;
    logic              ms_ex_to_es;
    logic              fwd_valid;
    logic [4:0]        fwd_dest;
    logic [31:0]       fwd_data;
    logic              fwd_block;

    int checks = 0;
    int errors = 0;

    mem_resp_stage #(.PASS_W(PASS_W), .CNT_W(CNT_W)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .es_to_ms_valid    (es_to_ms_valid),
        .ms_allowin        (ms_allowin),
        .es_ld_op          (es_ld_op),
        .es_need_resp      (es_need_resp),
        .es_addr_lo        (es_addr_lo),
        .es_rt_value       (es_rt_value),
        .es_alu_result     (es_alu_result),
        .es_gr_we          (es_gr_we),
        .es_dest           (es_dest),
        .es_pc             (es_pc),
        .es_ex             (es_ex),
        .es_excode         (es_excode),
        .es_pass           (es_pass),
        .es_cancel_req     (es_cancel_req),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .ws_allowin        (ws_allowin),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_ws_gr_we       (ms_ws_gr_we),
        .ms_ws_dest        (ms_ws_dest),
        .ms_ws_result      (ms_ws_result),
        .ms_ws_pc          (ms_ws_pc),
        .ms_ws_alu_result  (ms_ws_alu_result),
        .ms_ws_ex          (ms_ws_ex),
        .ms_ws_excode      (ms_ws_excode),
        .ms_ws_pass        (ms_ws_pass),
        .ex_from_ws        (ex_from_ws),
        .ms_ex_to_es       (ms_ex_to_es),
        .fwd_valid         (fwd_valid),
        .fwd_dest          (fwd_dest),
        .fwd_data          (fwd_data),
        .fwd_block         (fwd_block)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        es_to_ms_valid    = 1'b0;
        es_ld_op          = OP_NONE;
        es_need_resp      = 1'b0;
        es_addr_lo        = 2'd0;
        es_rt_value       = '0;
        es_alu_result     = '0;
        es_gr_we          = 1'b0;
        es_dest           = '0;
        es_pc             = '0;
        es_ex             = 1'b0;
        es_excode         = '0;
        es_pass           = '0;
        es_cancel_req     = 1'b0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = '0;
        ws_allowin        = 1'b1;
        ex_from_ws        = 1'b0;
    endtask

    task automatic issue(input logic [2:0] op, input logic need, input logic [1:0] a,
                         input logic [31:0] rt, input logic [31:0] alu, input logic [4:0] dest);
        es_to_ms_valid = 1'b1;
        es_ld_op       = op;
        es_need_resp   = need;
        es_addr_lo     = a;
        es_rt_value    = rt;
        es_alu_result  = alu;
        es_gr_we       = 1'b1;
        es_dest        = dest;
        es_pc          = alu;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        idle();
        resetn = 1'b0;
        #3;
        chk("rst_to_ws_valid", 32'(ms_to_ws_valid), 32'd0);
        chk("rst_fwd_valid",   32'(fwd_valid), 32'd0);
        chk("rst_fwd_block",   32'(fwd_block), 32'd0);
        chk("rst_result",      ms_ws_result, 32'd0);
        chk("rst_ex_to_es",    32'(ms_ex_to_es), 32'd0);
        chk("rst_cancel_cnt",  32'(dut.cancel_cnt_q), 32'd0);
        #9 resetn = 1'b1;

        // LH, response one cycle after entry
        next(); issue(OP_LH, 1'b1, 2'd2, 32'h0, 32'h0000_1002, 5'd5); settle();
        chk("lh_allowin", 32'(ms_allowin), 32'd1);
        next(); settle();
        chk("lh_wait_block", 32'(fwd_block), 32'd1);
        chk("lh_wait_to_ws", 32'(ms_to_ws_valid), 32'd0);
        next(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'h8001_7F00; settle();
        chk("lh_to_ws",     32'(ms_to_ws_valid), 32'd1);
        chk("lh_result",    ms_ws_result, 32'hFFFF_8001);
        chk("lh_fwd_data",  fwd_data, 32'hFFFF_8001);
        chk("lh_fwd_block", 32'(fwd_block), 32'd0);
        chk("lh_fwd_valid", 32'(fwd_valid), 32'd1);
        chk("lh_fwd_dest",  32'(fwd_dest), 32'd5);
        next(); settle();
        chk("lh_gone", 32'(ms_to_ws_valid), 32'd0);

        // LWR then back-to-back LWL
        next(); issue(OP_LWR, 1'b1, 2'd1, 32'hAABB_CCDD, 32'h0000_2001, 5'd6); settle();
        next(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1122_3344;
        issue(OP_LWL, 1'b1, 2'd2, 32'hAABB_CCDD, 32'h0000_2002, 5'd7); settle();
        chk("lwr_result",  ms_ws_result, 32'hAA11_2233);
        chk("lwr_allowin", 32'(ms_allowin), 32'd1);
        next(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1122_3344; settle();
        chk("lwl_result", ms_ws_result, 32'h2233_44DD);
        chk("lwl_dest",   32'(ms_ws_dest), 32'd7);

        // LW response while WB stalls: captured and held
        next(); issue(OP_LW, 1'b1, 2'd0, 32'h0, 32'h0000_3000, 5'd8); ws_allowin = 1'b0; settle();
        next(); ws_allowin = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'hDEAD_BEEF; settle();
        chk("buf_first_to_ws",  32'(ms_to_ws_valid), 32'd1);
        chk("buf_first_allowin", 32'(ms_allowin), 32'd0);
        for (int i = 0; i < 2; i++) begin
            next(); ws_allowin = 1'b0; data_sram_rdata = 32'h1234_5678; settle();
            chk("buf_hold_result", ms_ws_result, 32'hDEAD_BEEF);
            chk("buf_hold_to_ws",  32'(ms_to_ws_valid), 32'd1);
        end
        next(); data_sram_rdata = 32'h5555_AAAA; settle();
        chk("buf_release_result",  ms_ws_result, 32'hDEAD_BEEF);
        chk("buf_release_allowin", 32'(ms_allowin), 32'd1);
        next(); settle();
        chk("buf_gone", 32'(ms_to_ws_valid), 32'd0);

        // Flush of a waiting load plus EXE cancel, then LBU
        next(); issue(OP_LW, 1'b1, 2'd0, 32'h0, 32'h0000_4000, 5'd9); settle();
        next(); ex_from_ws = 1'b1; es_cancel_req = 1'b1; settle();
        next(); settle();
        chk("flush_cnt2", 32'(dut.cancel_cnt_q), 32'd2);
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'hFFFF_FFFF;
        issue(OP_LBU, 1'b1, 2'd3, 32'h0, 32'h0000_4003, 5'd10); settle();
        chk("flush_allowin",   32'(ms_allowin), 32'd1);
        chk("flush_drop1_vld", 32'(ms_to_ws_valid), 32'd0);
        next(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0000_00FF; settle();
        chk("flush_cnt1",      32'(dut.cancel_cnt_q), 32'd1);
        chk("flush_drop2_vld", 32'(ms_to_ws_valid), 32'd0);
        chk("flush_drop2_blk", 32'(fwd_block), 32'd1);
        next(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'hC500_0000; settle();
        chk("lbu_cnt0",   32'(dut.cancel_cnt_q), 32'd0);
        chk("lbu_to_ws",  32'(ms_to_ws_valid), 32'd1);
        chk("lbu_result", ms_ws_result, 32'h0000_00C5);

        // Saturated cancel counter blocks entry until one response drains
        next(); issue(OP_LW, 1'b1, 2'd0, 32'h0, 32'h0000_5000, 5'd1); settle();
        next(); ex_from_ws = 1'b1; es_cancel_req = 1'b1; settle();
        next(); issue(OP_LW, 1'b1, 2'd0, 32'h0, 32'h0000_5004, 5'd2); settle();
        chk("sat_allowin_cnt2", 32'(ms_allowin), 32'd1);
        next(); ex_from_ws = 1'b1; settle();
        next(); issue(OP_LW, 1'b1, 2'd0, 32'h0, 32'h0000_5008, 5'd3); settle();
        chk("sat_cnt3",    32'(dut.cancel_cnt_q), 32'd3);
        chk("sat_allowin", 32'(ms_allowin), 32'd0);
        next(); data_sram_data_ok = 1'b1;
        issue(OP_LW, 1'b1, 2'd0, 32'h0, 32'h0000_5008, 5'd3); settle();
        chk("sat_drain_allowin", 32'(ms_allowin), 32'd0);
        next(); settle();
        chk("sat_after_cnt2",    32'(dut.cancel_cnt_q), 32'd2);
        chk("sat_after_allowin", 32'(ms_allowin), 32'd1);
        chk("sat_not_entered",   32'(dut.ms_valid_q), 32'd0);
        next(); data_sram_data_ok = 1'b1; settle();
        next(); data_sram_data_ok = 1'b1; settle();
        next(); settle();
        chk("sat_drained", 32'(dut.cancel_cnt_q), 32'd0);

        // Async reset mid-WAIT with cancels outstanding
        next(); issue(OP_LW, 1'b1, 2'd0, 32'h0, 32'h0000_6000, 5'd4); settle();
        next(); ex_from_ws = 1'b1; es_cancel_req = 1'b1; settle();
        next(); issue(OP_LW, 1'b1, 2'd0, 32'h0, 32'h0000_6004, 5'd11); settle();
        next(); settle();
        chk("arst_pre_block", 32'(fwd_block), 32'd1);
        chk("arst_pre_cnt",   32'(dut.cancel_cnt_q), 32'd2);
        #2 resetn = 1'b0;
        #1;
        chk("arst_ms_valid",  32'(dut.ms_valid_q), 32'd0);
        chk("arst_to_ws",     32'(ms_to_ws_valid), 32'd0);
        chk("arst_fwd_valid", 32'(fwd_valid), 32'd0);
        chk("arst_fwd_block", 32'(fwd_block), 32'd0);
        chk("arst_fwd_dest",  32'(fwd_dest), 32'd0);
        chk("arst_fwd_data",  fwd_data, 32'd0);
        chk("arst_cnt",       32'(dut.cancel_cnt_q), 32'd0);
        #10 resetn = 1'b1;

        // Non-load after reset passes alu_result straight through
        next(); issue(OP_NONE, 1'b0, 2'd0, 32'h0, 32'h1234_5678, 5'd12); settle();
        next(); settle();
        chk("alu_to_ws",  32'(ms_to_ws_valid), 32'd1);
        chk("alu_result", ms_ws_result, 32'h1234_5678);
        chk("alu_block",  32'(fwd_block), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
